// File: rtl/bsg_zynq_fifo_combiner.sv
// bsg_zynq_fifo_combiner: reduces groups of PS->PL FIFO heads into registered PL->PS words,
// with per-channel saturating delivery counters and last AXI write address capture.
module bsg_zynq_fifo_combiner #(
  parameter int width_p       = 32,
  parameter int num_out_p     = 2,
  parameter int group_p       = 2,
  parameter int count_width_p = 16,
  parameter int addr_width_p  = 6
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [num_out_p*group_p*width_p-1:0]   in_data_i,
  input  logic [num_out_p*group_p-1:0]           in_v_i,
  output logic [num_out_p*group_p-1:0]           in_yumi_o,
  output logic [num_out_p*width_p-1:0]           out_data_o,
  output logic [num_out_p-1:0]                   out_v_o,
  input  logic [num_out_p-1:0]                   out_ready_i,
  input  logic [1:0]                             mode_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  logic                                   aw_v_i,
  input  logic [addr_width_p-1:0]                aw_addr_i,
  output logic [num_out_p*count_width_p-1:0]     count_o,
  output logic [num_out_p-1:0]                   sat_o,
  output logic [addr_width_p-1:0]                last_addr_o
);
  genvar k;
  for (k = 0; k < num_out_p; k++) begin : ch
    logic [width_p-1:0] red, w, data;
    logic [count_width_p-1:0] cnt, cnt_next;
    logic full, fire, deliver, sat;
    always_comb begin
      red = in_data_i[k*group_p*width_p +: width_p];
      w = '0;
      for (int g = 1; g < group_p; g++) begin
        w = in_data_i[(k*group_p+g)*width_p +: width_p];
        red = mode_i == 2'd0 ? red + w :
              mode_i == 2'd1 ? red ^ w :
              mode_i == 2'd2 ? (w > red ? w : red) :
                               (w < red ? w : red);
      end
    end
    assign fire = enable_i & (&in_v_i[k*group_p +: group_p]) & (~full | out_ready_i[k]) & ~areset;
    assign deliver = full & out_ready_i[k];
    // clear wins over the old count but still accounts for a same-cycle delivery
    assign cnt_next = clear_i ? count_width_p'(deliver) : cnt + count_width_p'(deliver & ~&cnt);
    always_ff @(posedge aclk)
      if (areset) begin
        full <= 1'b0;
        data <= '0;
        cnt  <= '0;
        sat  <= 1'b0;
      end else begin
        full <= fire | (full & ~out_ready_i[k]);
        if (fire) data <= red;
        cnt  <= cnt_next;
        sat  <= ~clear_i & (sat | &cnt_next);
      end
    assign in_yumi_o[k*group_p +: group_p]         = {group_p{fire}};
    assign out_data_o[k*width_p +: width_p]         = data;
    assign out_v_o[k]                               = full;
    assign count_o[k*count_width_p +: count_width_p] = cnt;
    assign sat_o[k]                                 = sat;
  end
  always_ff @(posedge aclk)
    if (areset) last_addr_o <= '0;
    else if (aw_v_i) last_addr_o <= aw_addr_i;
endmodule

// File: tb/tb_bsg_zynq_fifo_combiner.sv
// tb_bsg_zynq_fifo_combiner: directed and randomized checks of the FIFO combiner against a behavioural model.
module tb_bsg_zynq_fifo_combiner;
  logic aclk = 1'b0, areset = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0] in_v = '0, yumi;
  logic [63:0] out_data;
  logic [1:0] out_v, out_ready = '0, sat, mode = '0;
  logic enable = 1'b0, clear = 1'b0, aw_v = 1'b0;
  logic [5:0] aw_addr = '0, last_addr, s_last_addr;
  logic [31:0] count;
  logic [31:0] s_in_data = '0, s_out_data;
  logic s_in_v = 1'b0, s_yumi, s_out_v, s_ready = 1'b0, s_clear = 1'b0, s_sat;
  logic [1:0] s_count;
  int checks = 0, errors = 0;
  logic pend [2];
  logic [31:0] pend_d [2];
  int unsigned cnt_m [2];
  logic sat_m [2];
  logic [5:0] addr_m;
  logic f [2];
  logic d;

  always #5 aclk = ~aclk;

  bsg_zynq_fifo_combiner dut (
    .aclk(aclk), .areset(areset), .in_data_i(in_data), .in_v_i(in_v), .in_yumi_o(yumi),
    .out_data_o(out_data), .out_v_o(out_v), .out_ready_i(out_ready), .mode_i(mode),
    .enable_i(enable), .clear_i(clear), .aw_v_i(aw_v), .aw_addr_i(aw_addr),
    .count_o(count), .sat_o(sat), .last_addr_o(last_addr)
  );

  bsg_zynq_fifo_combiner #(.num_out_p(1), .group_p(1), .count_width_p(2)) u_sat (
    .aclk(aclk), .areset(areset), .in_data_i(s_in_data), .in_v_i(s_in_v), .in_yumi_o(s_yumi),
    .out_data_o(s_out_data), .out_v_o(s_out_v), .out_ready_i(s_ready), .mode_i(mode),
    .enable_i(enable), .clear_i(s_clear), .aw_v_i(aw_v), .aw_addr_i(aw_addr),
    .count_o(s_count), .sat_o(s_sat), .last_addr_o(s_last_addr)
  );

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      2'd0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      2'd1: return a ^ b;
      2'd2: return a > b ? a : b;
      default: return a < b ? a : b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    in_v = 4'hF;
    enable = 1'b1;
    tick; tick;
    chk("rst_yumi", yumi, 0);
    chk("rst_out_v", out_v, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_sat", sat, 0);
    chk("rst_addr", last_addr, 0);
    in_v = 4'h0;
    areset = 1'b0;
    #1;
    chk("post_rst_out_v", out_v, 0);
    chk("post_rst_count", count, 0);
    // add wraps modulo 2^32
    in_data = {32'd7, 32'd5, 32'h2, 32'hFFFF_FFFF};
    in_v = 4'hF; out_ready = 2'b11; mode = 2'd0;
    #1;
    chk("add_yumi", yumi, 4'hF);
    tick;
    chk("add_out_v", out_v, 2'b11);
    chk("add_data", out_data, {32'hC, 32'h1});
    chk("add_count0", count, 0);
    in_v = 4'h0;
    #1;
    chk("add_yumi_once", yumi, 0);
    tick;
    chk("add_drain", out_v, 0);
    chk("add_count1", count, 32'h0001_0001);
    in_data = {64'd0, 32'h7FFF_FFFF, 32'h8000_0000};
    in_v = 4'b0011; mode = 2'd2;
    tick;
    chk("max", out_data[31:0], 32'h8000_0000);
    mode = 2'd3;
    tick;
    chk("min", out_data[31:0], 32'h7FFF_FFFF);
    chk("min_v", out_v, 2'b01);
    in_v = 4'h0;
    tick;
    // ch0 stalls while ch1 keeps firing
    in_data = {32'd1, 32'd1, 32'd2, 32'd1};
    in_v = 4'hF; out_ready = 2'b10; mode = 2'd0;
    #1;
    chk("bp_first_yumi", yumi, 4'hF);
    tick;
    in_data[63:0] = {32'd20, 32'd10};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_yumi", yumi, 4'b1100);
      chk("bp_data", out_data[31:0], 32'd3);
      chk("bp_v", out_v[0], 1'b1);
      tick;
    end
    out_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      in_data[63:0] = {32'd1, 32'(i * 100)};
      #1;
      chk("thru_yumi", yumi, 4'hF);
      tick;
      chk("thru_v", out_v, 2'b11);
      chk("thru_data", out_data[31:0], 32'(i * 100 + 1));
    end
    enable = 1'b0;
    #1;
    chk("dis_yumi", yumi, 0);
    tick;
    chk("dis_drain", out_v, 0);
    aw_v = 1'b1; aw_addr = 6'h2C;
    tick;
    chk("aw_load", last_addr, 6'h2C);
    aw_v = 1'b0; aw_addr = 6'h11;
    tick;
    chk("aw_hold", last_addr, 6'h2C);
    in_v = 4'h0; enable = 1'b1; mode = 2'd3; s_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      s_in_v = c < 5;
      s_in_data = 32'hA000_0000 + 32'(c);
      tick;
      if (c < 5) chk("sat_pass", s_out_data, 32'hA000_0000 + 32'(c));
      chk("sat_count", s_count, (c > 3) ? 3 : c);
      chk("sat_flag", s_sat, c >= 3);
    end
    s_in_v = 1'b1;
    tick;
    s_in_v = 1'b0; s_clear = 1'b1;
    tick;
    s_clear = 1'b0;
    chk("clr_count", s_count, 1);
    chk("clr_sat", s_sat, 0);
    in_v = 4'hF; out_ready = 2'b00;
    tick;
    chk("mid_full", out_v, 2'b11);
    areset = 1'b1;
    #1;
    chk("mid_rst_yumi", yumi, 0);
    tick;
    chk("mid_rst_v", out_v, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_addr", last_addr, 0);
    areset = 1'b0; in_v = 4'h0;
    tick;
    chk("mid_lost", out_v, 0);
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; pend_d[k] = '0; cnt_m[k] = 0; sat_m[k] = 1'b0;
    end
    addr_m = '0;
    for (int c = 0; c < 400; c++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_v = 4'($urandom); out_ready = 2'($urandom); mode = 2'($urandom);
      enable = $urandom_range(3) != 0; clear = $urandom_range(19) == 0;
      aw_v = 1'($urandom); aw_addr = 6'($urandom);
      #1;
      for (int k = 0; k < 2; k++)
        f[k] = enable && (&in_v[2*k +: 2]) && (!pend[k] || out_ready[k]);
      chk("rnd_yumi", yumi, {{2{f[1]}}, {2{f[0]}}});
      for (int k = 0; k < 2; k++) begin
        chk("rnd_v", out_v[k], pend[k]);
        if (pend[k]) chk("rnd_data", out_data[32*k +: 32], pend_d[k]);
        chk("rnd_count", count[16*k +: 16], cnt_m[k]);
        chk("rnd_sat", sat[k], sat_m[k]);
      end
      chk("rnd_addr", last_addr, addr_m);
      @(posedge aclk);
      for (int k = 0; k < 2; k++) begin
        d = pend[k] && out_ready[k];
        if (clear) begin
          cnt_m[k] = d; sat_m[k] = 1'b0;
        end else if (d && cnt_m[k] < 65535) cnt_m[k]++;
        if (!clear && cnt_m[k] == 65535) sat_m[k] = 1'b1;
        if (f[k]) begin
          pend[k] = 1'b1;
          pend_d[k] = model(mode, in_data[64*k +: 32], in_data[64*k+32 +: 32]);
        end else if (d) pend[k] = 1'b0;
      end
      if (aw_v) addr_m = aw_addr;
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
